// File: rtl/dowhile_pkg.sv
// rtl/dowhile_pkg.sv - shared enums for the do-while loop sequencer
package dowhile_pkg;

   // Continue-while test applied to the counter after each delivered iteration
   typedef enum logic [1:0] {
      COND_LT = 2'b00,
      COND_LE = 2'b01,
      COND_NE = 2'b10,
      COND_GT = 2'b11
   } cond_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ITER = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // How the last run ended; held alongside final_count
   typedef enum logic [1:0] {
      ST_OK    = 2'b00,
      ST_ABORT = 2'b01,
      ST_WDOG  = 2'b10
   } status_e;

endpackage

// File: rtl/dowhile_loop_counter_if.sv
// rtl/dowhile_loop_counter_if.sv - iteration offer channel (valid/ready)
interface dowhile_loop_counter_if #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 9
);
   logic             iter_valid;
   logic             iter_ready;
   logic [WIDTH-1:0] iter_count;
   logic [IDX_W-1:0] iter_idx;

   // Sequencer side offers iterations
   modport master (
      output iter_valid,
      output iter_count,
      output iter_idx,
      input  iter_ready
   );

   // Consumer side accepts iterations
   modport slave (
      input  iter_valid,
      input  iter_count,
      input  iter_idx,
      output iter_ready
   );
endinterface

// File: rtl/dowhile_cond_cmp.sv
// rtl/dowhile_cond_cmp.sv - unsigned continue-condition comparator
module dowhile_cond_cmp
   import dowhile_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] lim,
   input  cond_e            mode,
   output logic             cont
);

   // Evaluate the selected continue-while relation on the wrapped counter
   always_comb begin
      cont = 1'b0;
      case (mode)
         COND_LT: cont = (cnt <  lim);
         COND_LE: cont = (cnt <= lim);
         COND_NE: cont = (cnt != lim);
         default: cont = (cnt >  lim);
      endcase
   end

endmodule

// File: rtl/dowhile_loop_counter.sv
// rtl/dowhile_loop_counter.sv - do-while loop sequencer with abort and watchdog
module dowhile_loop_counter
   import dowhile_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_ITER = 256,
   parameter int IDX_W    = $clog2(MAX_ITER + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [WIDTH-1:0]       init_val,
   input  logic [WIDTH-1:0]       limit_val,
   input  logic [WIDTH-1:0]       step,
   input  logic                   dir,
   input  logic [1:0]             cond_mode,
   input  logic                   abort,
   dowhile_loop_counter_if.master iter,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       final_count,
   output logic [1:0]             status
);

   // Index of the last iteration the watchdog allows in one run
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_ITER - 1);

   // Counter step with modulo-2^WIDTH wrap in either direction
   function automatic logic [WIDTH-1:0] step_next(
      input logic [WIDTH-1:0] base,
      input logic [WIDTH-1:0] mag,
      input logic             down
   );
      return down ? (base - mag) : (base + mag);
   endfunction

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] cnt_q,    cnt_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic [WIDTH-1:0] lim_q,    lim_d;
   logic [WIDTH-1:0] step_q,   step_d;
   logic             dir_q,    dir_d;
   cond_e            mode_q,   mode_d;
   logic             valid_q,  valid_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic [WIDTH-1:0] final_q,  final_d;
   status_e          status_q, status_d;

   logic cont;
   logic hs;

   assign hs = valid_q & iter.iter_ready;

   dowhile_cond_cmp #(
      .WIDTH (WIDTH)
   ) u_cond (
      .cnt  (cnt_q),
      .lim  (lim_q),
      .mode (mode_q),
      .cont (cont)
   );

   // Next-state: launch on start, advance or exit per handshake, one-cycle DONE
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      lim_d    = lim_q;
      step_d   = step_q;
      dir_d    = dir_q;
      mode_d   = mode_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      final_d  = final_q;
      status_d = status_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Body runs before the first test, so the first offer is already stepped
               cnt_d   = step_next(init_val, step, dir);
               idx_d   = '0;
               lim_d   = limit_val;
               step_d  = step;
               dir_d   = dir;
               mode_d  = cond_e'(cond_mode);
               state_d = S_ITER;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_ITER: begin
            if (abort) begin
               // Abort wins over continue/exit; a same-cycle handshake still delivered
               state_d  = S_DONE;
               valid_d  = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               final_d  = cnt_q;
               status_d = ST_ABORT;
            end else if (hs) begin
               if (cont && (idx_q != LAST_IDX)) begin
                  cnt_d = step_next(cnt_q, step_q, dir_q);
                  idx_d = idx_q + IDX_W'(1);
               end else begin
                  state_d  = S_DONE;
                  valid_d  = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  final_d  = cnt_q;
                  status_d = cont ? ST_WDOG : ST_OK;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything, no done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         lim_q    <= '0;
         step_q   <= '0;
         dir_q    <= 1'b0;
         mode_q   <= COND_LT;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         final_q  <= '0;
         status_q <= ST_OK;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lim_q    <= lim_d;
         step_q   <= step_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         final_q  <= final_d;
         status_q <= status_d;
      end
   end

   assign iter.iter_valid = valid_q;
   assign iter.iter_count = cnt_q;
   assign iter.iter_idx   = idx_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign final_count     = final_q;
   assign status          = status_q;

endmodule

// File: tb/tb_dowhile_loop_counter.sv
// tb/tb_dowhile_loop_counter.sv - scoreboard bench for dowhile_loop_counter
module tb_dowhile_loop_counter;
   import dowhile_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, start_b;
   logic [3:0] init_v, lim_v, step_v;
   logic       dir_v;
   logic [1:0] mode_v;
   logic       abort_v;
   logic       rdy;
   int         rdy_mode;

   logic       busy_a, done_a, busy_b, done_b;
   logic [3:0] final_a, final_b;
   logic [1:0] status_a, status_b;

   dowhile_loop_counter_if #(.WIDTH(4), .IDX_W(9)) ifa ();
   dowhile_loop_counter_if #(.WIDTH(4), .IDX_W(4)) ifb ();
   assign ifa.iter_ready = rdy;
   assign ifb.iter_ready = rdy;

   dowhile_loop_counter #(.WIDTH(4), .MAX_ITER(256)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .init_val(init_v), .limit_val(lim_v),
      .step(step_v), .dir(dir_v), .cond_mode(mode_v), .abort(abort_v), .iter(ifa),
      .busy(busy_a), .done(done_a), .final_count(final_a), .status(status_a)
   );

   dowhile_loop_counter #(.WIDTH(4), .MAX_ITER(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .init_val(init_v), .limit_val(lim_v),
      .step(step_v), .dir(dir_v), .cond_mode(mode_v), .abort(abort_v), .iter(ifb),
      .busy(busy_b), .done(done_b), .final_count(final_b), .status(status_b)
   );

   typedef struct { int cnt; int idx; } iter_t;
   typedef struct { int fin; int st; } res_t;
   iter_t iq[$];
   res_t  rq[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic mon_iter(input int c, input int i);
      iter_t e;
      if (iq.size() == 0) begin
         check("unexpected iteration", 1, 0);
      end else begin
         e = iq.pop_front();
         check("iter_count", c, e.cnt);
         check("iter_idx", i, e.idx);
      end
   endtask

   task automatic mon_res(input int f, input int s);
      res_t e;
      if (rq.size() == 0) begin
         check("unexpected done", 1, 0);
      end else begin
         e = rq.pop_front();
         check("final_count", f, e.fin);
         check("status", s, e.st);
      end
   endtask

   // Monitor: pop and compare on every accepted iteration and every done pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.iter_valid && ifa.iter_ready) mon_iter(int'(ifa.iter_count), int'(ifa.iter_idx));
         if (ifb.iter_valid && ifb.iter_ready) mon_iter(int'(ifb.iter_count), int'(ifb.iter_idx));
         if (done_a) mon_res(int'(final_a), int'(status_a));
         if (done_b) mon_res(int'(final_b), int'(status_b));
      end
   end

   // Consumer ready pattern: 0 always ready, 1 toggling, 2 stalled
   initial begin
      rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            default: rdy = 1'b0;
         endcase
      end
   end

   task automatic push_iter(input int c, input int i);
      iter_t e;
      e.cnt = c;
      e.idx = i;
      iq.push_back(e);
   endtask

   task automatic push_res(input int f, input int s);
      res_t e;
      e.fin = f;
      e.st  = s;
      rq.push_back(e);
   endtask

   task automatic launch(input bit use_b, input logic [3:0] init, input logic [3:0] lim,
                         input logic [3:0] stp, input logic d, input logic [1:0] m);
      @(posedge clk);
      #1;
      init_v = init;
      lim_v  = lim;
      step_v = stp;
      dir_v  = d;
      mode_v = m;
      if (use_b) start_b = 1'b1;
      else       start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input bit use_b, input int budget, output int cyc);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (use_b ? done_b : done_a) break;
         if (cyc >= budget) begin
            check("done timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic drained(input string name);
      @(posedge clk);
      #1;
      check({name, " iter queue left"}, iq.size(), 0);
      check({name, " result queue left"}, rq.size(), 0);
      iq.delete();
      rq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "bench did not terminate");
   end

   initial begin
      int cyc;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_v = 1'b0;
      init_v = '0; lim_v = '0; step_v = '0; dir_v = 1'b0; mode_v = '0;
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset valid_a", int'(ifa.iter_valid), 0);
      check("reset busy_a", int'(busy_a), 0);
      check("reset done_a", int'(done_a), 0);
      check("reset final_a", int'(final_a), 0);
      check("reset status_a", int'(status_a), 0);
      check("reset valid_b", int'(ifb.iter_valid), 0);
      rst_n = 1'b1;

      // 1: 0 up by 1 while <14 -> 1..14
      for (int i = 1; i <= 14; i++) push_iter(i, i - 1);
      push_res(14, 0);
      launch(1'b0, 4'd0, 4'd14, 4'd1, 1'b0, 2'b00);
      check("t1 busy", int'(busy_a), 1);
      wait_done(1'b0, 40, cyc);
      check("t1 done latency", cyc, 15);
      repeat (3) @(posedge clk);
      #1;
      check("t1 final held", int'(final_a), 14);
      check("t1 status held", int'(status_a), 0);
      check("t1 busy after", int'(busy_a), 0);
      drained("t1");

      // 2: condition already false -> exactly one body execution
      push_iter(6, 0);
      push_res(6, 0);
      launch(1'b0, 4'd5, 4'd3, 4'd1, 1'b0, 2'b00);
      wait_done(1'b0, 20, cyc);
      drained("t2");

      // 3: 14+3 wraps to 1, NE 1 exits at once
      push_iter(1, 0);
      push_res(1, 0);
      launch(1'b0, 4'd14, 4'd1, 4'd3, 1'b0, 2'b10);
      wait_done(1'b0, 20, cyc);
      drained("t3");

      // 4: count down by 2 while >4, consumer stalls every other cycle
      rdy_mode = 1;
      push_iter(8, 0); push_iter(6, 1); push_iter(4, 2);
      push_res(4, 0);
      launch(1'b0, 4'd10, 4'd4, 4'd2, 1'b1, 2'b11);
      wait_done(1'b0, 40, cyc);
      rdy_mode = 0;
      drained("t4");

      // 5: MAX_ITER=8, step 0 never leaves LT 15 -> watchdog
      for (int i = 0; i < 8; i++) push_iter(3, i);
      push_res(3, 2);
      launch(1'b1, 4'd3, 4'd15, 4'd0, 1'b0, 2'b00);
      wait_done(1'b1, 40, cyc);
      drained("t5");

      // 6: abort together with the handshake of idx 3
      for (int i = 1; i <= 4; i++) push_iter(i, i - 1);
      push_res(4, 1);
      launch(1'b0, 4'd0, 4'd14, 4'd1, 1'b0, 2'b00);
      for (int k = 0; k < 20; k++) begin
         if (ifa.iter_valid && (ifa.iter_idx == 9'd3)) break;
         @(posedge clk);
         #1;
      end
      abort_v = 1'b1;
      @(posedge clk);
      #1;
      abort_v = 1'b0;
      wait_done(1'b0, 10, cyc);
      check("t6 abort latency", cyc, 1);
      drained("t6");

      // 7: reset mid-run clears outputs immediately, no done afterwards
      rdy_mode = 2;
      launch(1'b0, 4'd0, 4'd14, 4'd1, 1'b0, 2'b00);
      @(posedge clk);
      #2;
      check("t7 valid before reset", int'(ifa.iter_valid), 1);
      rst_n = 1'b0;
      #1;
      check("t7 valid", int'(ifa.iter_valid), 0);
      check("t7 busy", int'(busy_a), 0);
      check("t7 done", int'(done_a), 0);
      check("t7 final", int'(final_a), 0);
      check("t7 status", int'(status_a), 0);
      check("t7 count", int'(ifa.iter_count), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rdy_mode = 0;
      repeat (4) begin
         @(negedge clk);
         check("t7 no done", int'(done_a), 0);
         check("t7 idle busy", int'(busy_a), 0);
      end
      drained("t7");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
